// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_magnitude_comparator
// Description : Multi-cycle WIDTH-bit magnitude comparator. Compares SLICE-bit
//               slices MSB-first, one per clock, with early exit on the first
//               mismatching slice. Unsigned or two's-complement compare.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int NPAD   = 1 << IDX_W;

    localparam logic [IDX_W-1:0] c_top_idx = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_b_nxt;
    logic             r_signed;
    logic             w_signed_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_eq;
    logic             w_eq_nxt;
    logic             r_gt;
    logic             w_gt_nxt;
    logic             r_lt;
    logic             w_lt_nxt;

    // Slice table padded to a power of two so any index value is in range.
    logic [SLICE-1:0] w_a_sl [NPAD];
    logic [SLICE-1:0] w_b_sl [NPAD];

    genvar gi;
    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_slice
            if (gi < NSLICE) begin : g_real
                assign w_a_sl[gi] = r_a[gi*SLICE +: SLICE];
                assign w_b_sl[gi] = r_b[gi*SLICE +: SLICE];
            end else begin : g_pad
                assign w_a_sl[gi] = '0;
                assign w_b_sl[gi] = '0;
            end
        end
    endgenerate

    // Flipping the sign bit of the top slice maps two's-complement order
    // onto unsigned order, so one unsigned comparator serves both modes.
    logic [SLICE-1:0] w_bias;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;

    assign w_bias = {r_signed && (r_idx == c_top_idx), {(SLICE-1){1'b0}}};
    assign w_sa   = w_a_sl[r_idx] ^ w_bias;
    assign w_sb   = w_b_sl[r_idx] ^ w_bias;

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_signed_nxt = r_signed;
        w_idx_nxt    = r_idx;
        w_done_nxt   = 1'b0;
        w_eq_nxt     = r_eq;
        w_gt_nxt     = r_gt;
        w_lt_nxt     = r_lt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_nxt      = a;
                    w_b_nxt      = b;
                    w_signed_nxt = signed_mode;
                    w_idx_nxt    = c_top_idx;
                    w_state_nxt  = ST_CMP;
                end
            end
            ST_CMP: begin
                if (w_sa != w_sb) begin
                    w_gt_nxt    = (w_sa > w_sb);
                    w_lt_nxt    = (w_sa < w_sb);
                    w_eq_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_idx != '0) begin
                    w_idx_nxt = r_idx - c_idx_one;
                end else begin
                    w_eq_nxt    = 1'b1;
                    w_gt_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_signed <= w_signed_nxt;
            r_idx    <= w_idx_nxt;
            r_done   <= w_done_nxt;
            r_eq     <= w_eq_nxt;
            r_gt     <= w_gt_nxt;
            r_lt     <= w_lt_nxt;
        end
    end

    assign busy = (r_state == ST_CMP);
    assign done = r_done;
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_magnitude_comparator
// Description : Scoreboard bench for seq_magnitude_comparator, 8/4 and 16/4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, sm0, busy0, done0, eq0, gt0, lt0;
    logic [7:0]  a0, b0;
    logic        start1, sm1, busy1, done1, eq1, gt1, lt1;
    logic [15:0] a1, b1;

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .signed_mode(sm0), .busy(busy0), .done(done0),
        .eq(eq0), .gt(gt0), .lt(lt0)
    );

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .signed_mode(sm1), .busy(busy1), .done(done1),
        .eq(eq1), .gt(gt1), .lt(lt1)
    );

    typedef struct {
        logic [2:0] res;   // {eq, gt, lt}
        int         lat;
        int         acc;   // edge number on which start is accepted
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [2:0] last0, last1;
    int         cyc   = 0;
    int         n_chk = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: numeric compare of the operand values; latency from the
    // position of the most significant differing slice.
    function automatic exp_t model(input int a, input int b, input logic sm,
                                   input int w, input int sl);
        exp_t    e;
        longint  va, vb;
        int      ns, mask;
        bit      found;
        ns   = w / sl;
        mask = (1 << sl) - 1;
        va   = longint'(a);
        vb   = longint'(b);
        if (sm && a[w-1]) va = va - (longint'(1) << w);
        if (sm && b[w-1]) vb = vb - (longint'(1) << w);
        if (va == vb)     e.res = 3'b100;
        else if (va > vb) e.res = 3'b010;
        else              e.res = 3'b001;
        e.lat = ns;
        found = 1'b0;
        for (int s = ns - 1; s >= 0; s--) begin
            if (!found && (((a >> (s*sl)) & mask) != ((b >> (s*sl)) & mask))) begin
                e.lat = ns - s;
                found = 1'b1;
            end
        end
        e.acc = 0;
        return e;
    endfunction

    task automatic mon(input int id, input logic dn, input logic bz, input logic [2:0] r);
        exp_t e;
        int   qs;
        qs = (id == 0) ? q0.size() : q1.size();
        if (dn) begin
            if (qs == 0) begin
                check($sformatf("unexpected_done%0d", id), 1, 0);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                check($sformatf("result%0d", id), int'(r), int'(e.res));
                check($sformatf("latency%0d", id), cyc - e.acc, e.lat);
                check($sformatf("busy_at_done%0d", id), int'(bz), 0);
                if (id == 0) last0 = e.res;
                else         last1 = e.res;
            end
        end else begin
            check($sformatf("hold%0d", id), int'(r), (id == 0) ? int'(last0) : int'(last1));
            if (qs > 0) begin
                e = (id == 0) ? q0[0] : q1[0];
                if (e.acc <= cyc) check($sformatf("busy_inflight%0d", id), int'(bz), 1);
            end else begin
                check($sformatf("busy_idle%0d", id), int'(bz), 0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, done0, busy0, {eq0, gt0, lt0});
            mon(1, done1, busy1, {eq1, gt1, lt1});
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic sm);
        exp_t e;
        int   g = 0;
        while (((id == 0) ? busy0 : busy1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("idle_wait", int'(g < 100), 1);
        if (id == 0) begin
            e     = model(int'(a[7:0]), int'(b[7:0]), sm, 8, 4);
            e.acc = cyc + 1;
            a0 = a[7:0]; b0 = b[7:0]; sm0 = sm; start0 = 1'b1;
            q0.push_back(e);
        end else begin
            e     = model(int'(a), int'(b), sm, 16, 4);
            e.acc = cyc + 1;
            a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
            q1.push_back(e);
        end
        @(negedge clk);
        if (id == 0) start0 = 1'b0;
        else         start1 = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", int'(g < 200), 1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          id, mode;
        rst_n = 1'b0;
        start0 = 1'b0; a0 = '0; b0 = '0; sm0 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; sm1 = 1'b0;
        last0 = 3'b000; last1 = 3'b000;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        check("reset_res", int'({eq0, gt0, lt0}), 0);
        check("reset_res16", int'({eq1, gt1, lt1}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 16'd15, 16'd15, 1'b0);
        issue(0, 16'd255, 16'd0, 1'b0);
        issue(0, 16'h4A, 16'h87, 1'b0);
        issue(0, 16'h4A, 16'h87, 1'b1);
        issue(0, 16'h80, 16'h7F, 1'b1);
        issue(0, 16'h4A, 16'h4C, 1'b0);
        // Start pulse while busy must be ignored.
        a0 = 8'h00; b0 = 8'h00; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain();

        issue(1, 16'h1234, 16'h1234, 1'b0);
        issue(1, 16'h8000, 16'h7FFF, 1'b1);
        issue(1, 16'h1234, 16'h1235, 1'b0);
        drain();

        for (int i = 0; i < 80; i++) begin
            id   = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            ra   = 16'($urandom);
            case (mode)
                0:       rb = 16'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (16'd1 << $urandom_range(0, (id == 0) ? 7 : 15));
            endcase
            issue(id, ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset in the middle of a compare aborts it without a done pulse.
        issue(0, 16'h33, 16'h33, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy0), 0);
        check("abort_res", int'({eq0, gt0, lt0}), 0);
        check("abort_done", int'(done0), 0);
        q0.delete();
        q1.delete();
        last0 = 3'b000;
        last1 = 3'b000;
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 16'h12, 16'h34, 1'b0);
        issue(0, 16'hF0, 16'h0F, 1'b1);
        issue(1, 16'hABCD, 16'hABC0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised multi-cycle magnitude comparator that generalises the fixed 4-bit/8-bit comparators to WIDTH-bit operands. It compares SLICE-bit slices one per clock, MSB slice first, and terminates early on the first mismatching slice. It supports unsigned and two's-complement signed compare and uses a start/busy/done handshake. It sits in the datapath library as the area-cheap alternative to a wide combinational compare.

Parameters:
WIDTH, 8, operand width in bits; must be an integer multiple of SLICE.
SLICE, 4, bits compared per cycle; must be >= 2.
NSLICE, WIDTH/SLICE, derived localparam: number of slices, which is also the maximum latency.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request to begin a compare; sampled only while busy=0
a  in  WIDTH  operand A; captured on the accepted start edge
b  in  WIDTH  operand B; captured on the accepted start edge
signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; captured with a and b
busy  out  1  high while a compare is in progress
done  out  1  one-cycle pulse when the result is valid
eq  out  1  result: a == b
gt  out  1  result: a > b
lt  out  1  result: a < b

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, eq=0, gt=0, lt=0.
  - Operand registers and slice index are cleared.
  - Reset asserted mid-compare aborts the compare; no done pulse is issued.
- States: IDLE and CMP.
- IDLE:
  - start=1 at a clock edge: capture a, b and signed_mode; set idx=NSLICE-1; go to CMP; busy=1.
  - done is driven to 0 on this edge.
- CMP, one slice per edge, slice s = bits [s*SLICE+SLICE-1 : s*SLICE]:
  - Top slice (idx=NSLICE-1) with signed_mode=1: invert the slice MSB of both operands, then compare unsigned. This is the sign-bias trick. All other slices always compare unsigned.
  - Slice values differ: set gt/lt from the slice compare, eq=0, done=1, busy=0, return to IDLE. This is the early exit.
  - Slices equal and idx>0: decrement idx; stay in CMP.
  - Slices equal and idx=0: eq=1, gt=0, lt=0, done=1, busy=0, return to IDLE.
- Latency: result valid k edges after the accepted start edge, where k = NSLICE - (index of the first differing slice). k ranges from 1 to NSLICE. Equal operands always take NSLICE edges.
- Exactly one of eq/gt/lt is 1 after the first completed compare. All three are 0 only between reset and the first done.
- Results hold until the next done. They are not cleared on start.
- done is high for exactly one cycle per compare.
- start while busy=1 is ignored: no re-capture and no effect on the result.
- start may be asserted in the cycle done=1. busy=0 then, so it is accepted on that edge. Back-to-back compares carry no dead cycle.
- a, b and signed_mode may change freely after capture without affecting the in-flight compare.
- WIDTH == SLICE is legal: every compare completes in 1 edge.

Test Plan (WIDTH=8, SLICE=4 unless stated):
1. a=15, b=15, unsigned, start pulse -> busy for 2 cycles; done on the 2nd edge after start; eq=1, gt=0, lt=0.
2. a=255, b=0, unsigned -> done on the 1st edge (top slices F vs 0); gt=1. Then a=74 (0x4A), b=135 (0x87), unsigned -> done after 1 edge; lt=1.
3. a=0x4A, b=0x87, signed_mode=1 (74 vs -121) -> done after 1 edge; gt=1. Then a=0x80, b=0x7F, signed -> lt=1.
4. a=0x4A, b=0x4C -> top slices equal, low slice A<C; done on the 2nd edge; lt=1. During busy, pulse start with a=0, b=0 -> ignored; result is still lt=1.
5. Start a compare with a=0x33, b=0x33; deassert rst_n for half a cycle after the 1st edge -> busy=0 and eq/gt/lt=0 immediately. No done pulse follows. A new start after reset completes normally.
6. Back-to-back: assert start in the done cycle with new operands -> second compare accepted with no idle cycle. Then WIDTH=16, SLICE=4: a=0x1234, b=0x1234 -> done after 4 edges; eq=1.
